rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WA, write data, write_enable) between NUM_REQ writeback requesters: the ALU and multi-cycle units.
- Uses valid/ready handshakes and round-robin arbitration.
- Keeps a per-register busy scoreboard, set at dispatch and cleared at writeback, so the decode stage can stall on read-after-write hazards against RA1/RA2.
- Sits between the execute units and reg_file.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/rf_wb_arbiter.sv | 112 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file writeback package: shared widths, register typedefs, pointer helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 2**ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Increment modulo n; with n==1 this always yields 0.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational from req; pointer moves at the edge after an advance.
// Backpressure: grant is only ever given to an asserted req; no req means no grant.
// Ports: CLK/RST_N clock and async active-low reset; req request vector;
//        advance = the granted requester transferred; grant one-hot grant vector.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    // Scan offsets 0..N-1 from the pointer; the first asserted req wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                end
            end
        end
    end

    // Winner moves to lowest priority; with N==1 the pointer stays at 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= PW'(wrap_inc(int'(gidx), N));
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the reg_file write port among NUM_REQ units, with a busy scoreboard.
// Latency: 1 cycle from transfer (valid && ready) to write_enable/WA/WD.
// Backpressure: req_ready is a round-robin grant; losers hold valid/addr/data until granted.
// Ports: req_valid/req_addr/req_data/req_ready packed writeback channels (slot 0 = ALU);
//        rsv_valid/rsv_addr dispatch reservation; RA1/RA2 decode reads, stall hazard flag;
//        rsv_err double-reservation pulse; WA/WD/write_enable reg_file write port; busy scoreboard.
//        Macro WB_BYPASS_EN adds fwd1/fwd2 valid+data forwarding of the write-cycle value.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = rf_pkg::DATA_W,
    parameter int ADDR_W  = rf_pkg::ADDR_W
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         RA1,
    input  logic [ADDR_W-1:0]         RA2,
    output logic                      stall,
    output logic                      rsv_err,
    output logic [ADDR_W-1:0]         WA,
    output logic [DATA_W-1:0]         WD,
    output logic                      write_enable,
    output logic [2**ADDR_W-1:0]      busy
`ifdef WB_BYPASS_EN
    ,
    output logic                      fwd1_valid,
    output logic [DATA_W-1:0]         fwd1_data,
    output logic                      fwd2_valid,
    output logic [DATA_W-1:0]         fwd2_data
`endif
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REQ-1:0]  grant;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                rsv_err_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .req     (req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    // Ready is forced low while reset is held so nothing can be granted then.
    assign req_ready = grant & {NUM_REQ{RST_N}};
    assign xfer      = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clear then set: a reservation in the same cycle as the writeback marks a new pending write.
    always_comb begin
        busy_nxt = busy;
        if (xfer) begin
            busy_nxt[sel_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        rsv_err_nxt = rsv_valid && busy[rsv_addr] && !(xfer && (sel_addr == rsv_addr));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WA           <= '0;
            WD           <= '0;
            write_enable <= 1'b0;
            busy         <= '0;
            rsv_err      <= 1'b0;
        end else begin
            write_enable <= xfer;
            if (xfer) begin
                WA <= sel_addr;
                WD <= sel_data;
            end
            busy    <= busy_nxt;
            rsv_err <= rsv_err_nxt;
        end
    end

    // Uses current busy: a register cleared this cycle still stalls until the next one.
    assign stall = busy[RA1] | busy[RA2];

`ifdef WB_BYPASS_EN
    assign fwd1_valid = write_enable && (WA == RA1);
    assign fwd1_data  = WD;
    assign fwd2_valid = write_enable && (WA == RA2);
    assign fwd2_data  = WD;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed test-plan steps plus randomized traffic.
// Latency: checks registered outputs one cycle after each modelled transfer.
// Backpressure: random requesters hold valid/addr/data until granted.
module tb_rf_wb_arbiter;

    localparam int NR    = 2;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NREGS = 16;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              rsv_valid = 1'b0;
    logic [AW-1:0]     rsv_addr = '0;
    logic [AW-1:0]     RA1 = '0;
    logic [AW-1:0]     RA2 = '0;
    logic              stall;
    logic              rsv_err;
    logic [AW-1:0]     WA;
    logic [DW-1:0]     WD;
    logic              write_enable;
    logic [NREGS-1:0]  busy;
`ifdef WB_BYPASS_EN
    logic              fwd1_valid;
    logic [DW-1:0]     fwd1_data;
    logic              fwd2_valid;
    logic [DW-1:0]     fwd2_data;
`endif

    rf_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .RA1          (RA1),
        .RA2          (RA2),
        .stall        (stall),
        .rsv_err      (rsv_err),
        .WA           (WA),
        .WD           (WD),
        .write_enable (write_enable),
        .busy         (busy)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_valid   (fwd1_valid),
        .fwd1_data    (fwd1_data),
        .fwd2_valid   (fwd2_valid),
        .fwd2_data    (fwd2_data)
`endif
    );

    always #5 CLK = ~CLK;

    // Simple register file fed by the write port, to confirm committed values.
    logic [DW-1:0] tb_rf [NREGS];
    always @(posedge CLK) begin
        if (write_enable) tb_rf[WA] <= WD;
    end

    int total = 0;
    int fails = 0;

    // Reference model state.
    int               m_ptr;
    logic [NREGS-1:0] m_busy;
    bit               m_we;
    int               m_wa;
    int               m_wd;
    bit               m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_we   = 0;
        m_wa   = 0;
        m_wd   = 0;
        m_err  = 0;
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        req_valid[i]           = v;
        req_addr[i*AW +: AW]   = AW'(a);
        req_data[i*DW +: DW]   = DW'(d);
    endtask

    // Rotating-priority search from the model pointer.
    function automatic int exp_grant();
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    // One clock: check all outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle(output int g);
        int a;
        int d;
        bit e_err;
        @(negedge CLK);
        g = exp_grant();
        chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("stall", stall, m_busy[RA1] | m_busy[RA2]);
        chk("write_enable", write_enable, m_we);
        chk("WA", WA, m_wa);
        chk("WD", WD, m_wd);
        chk("rsv_err", rsv_err, m_err);
        chk("busy", busy, m_busy);
`ifdef WB_BYPASS_EN
        chk("fwd1_valid", fwd1_valid, m_we && (m_wa == int'(RA1)));
        chk("fwd2_valid", fwd2_valid, m_we && (m_wa == int'(RA2)));
        if (m_we) chk("fwd1_data", fwd1_data, m_wd);
`endif
        @(posedge CLK);
        a = 0;
        d = 0;
        if (g >= 0) begin
            a = int'(req_addr[g*AW +: AW]);
            d = int'(req_data[g*DW +: DW]);
        end
        e_err = rsv_valid && m_busy[rsv_addr] && !((g >= 0) && (a == int'(rsv_addr)));
        if (g >= 0) begin
            m_we      = 1;
            m_wa      = a;
            m_wd      = d;
            m_busy[a] = 1'b0;
            m_ptr     = (g + 1) % NR;
        end else begin
            m_we = 0;
        end
        if (rsv_valid) m_busy[rsv_addr] = 1'b1;
        m_err = e_err;
        #1;
    endtask

    initial begin
        int g;
        model_reset();

        // Reset with no clock edge yet.
        #1 RST_N = 1'b0;
        #1;
        chk("rst_we", write_enable, 0);
        chk("rst_wa", WA, 0);
        chk("rst_wd", WD, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", rsv_err, 0);
        set_req(0, 1, 3, 5);
        set_req(1, 1, 9, 73);
        #1;
        chk("rst_ready", req_ready, 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;

        // Round-robin: alternating grants 0,1,0,1 with one write per cycle.
        for (int k = 0; k < 4; k++) begin
            cycle(g);
            chk("rr_we", write_enable, 1);
            chk("rr_wa", WA, (k % 2 == 1) ? 9 : 3);
            chk("rr_wd", WD, (k % 2 == 1) ? 73 : 5);
        end
        set_req(1, 0, 9, 73);
        cycle(g);  // requester 0 alone; pointer now favours requester 1

        // Reset mid-grant.
        set_req(1, 1, 9, 73);
        #3 RST_N = 1'b0;
        #1;
        model_reset();
        chk("midrst_ready", req_ready, 0);
        chk("midrst_we", write_enable, 0);
        chk("midrst_wa", WA, 0);
        chk("midrst_wd", WD, 0);
        chk("midrst_busy", busy, 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        #1;
        chk("post_rst_grant0", req_ready, 2'b01);
        cycle(g);
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        cycle(g);

        // Hazard on R7.
        rsv_valid = 1'b1;
        rsv_addr  = 4'd7;
        cycle(g);
        rsv_valid = 1'b0;
        RA1       = 4'd7;
        #1;
        chk("haz_stall", stall, 1);
        cycle(g);
        cycle(g);
        set_req(1, 1, 7, 59);
        cycle(g);
        set_req(1, 0, 7, 59);
        chk("haz_release", stall, 0);
        chk("haz_wa", WA, 7);
        chk("haz_wd", WD, 59);
        cycle(g);
        chk("haz_rf_r7", tb_rf[7], 59);
        RA1 = 4'd0;

        // Same-cycle set and clear on R9.
        rsv_valid = 1'b1;
        rsv_addr  = 4'd9;
        cycle(g);
        set_req(0, 1, 9, 33);
        cycle(g);
        set_req(0, 0, 9, 33);
        rsv_valid = 1'b0;
        chk("same_busy9", busy[9], 1);
        chk("same_err", rsv_err, 0);
        cycle(g);

        // Double reservation of R12.
        rsv_valid = 1'b1;
        rsv_addr  = 4'd12;
        cycle(g);
        cycle(g);
        rsv_valid = 1'b0;
        chk("dbl_err", rsv_err, 1);
        chk("dbl_busy12", busy[12], 1);
        cycle(g);
        chk("dbl_err_pulse", rsv_err, 0);

`ifdef WB_BYPASS_EN
        RA1 = 4'd12;
        RA2 = 4'd6;
        set_req(0, 1, 6, 75);
        cycle(g);
        set_req(0, 0, 6, 75);
        chk("byp_fwd2_valid", fwd2_valid, 1);
        chk("byp_fwd2_data", fwd2_data, 75);
        chk("byp_fwd1_valid", fwd1_valid, 0);
        cycle(g);
`endif

        // Randomized traffic; losers hold their request until granted.
        for (int n = 0; n < 400; n++) begin
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_addr  = AW'($urandom_range(0, NREGS - 1));
            RA1       = AW'($urandom_range(0, NREGS - 1));
            RA2       = AW'($urandom_range(0, NREGS - 1));
            cycle(g);
            for (int i = 0; i < NR; i++) begin
                if (!(req_valid[i] && g != i)) begin
                    set_req(i, ($urandom_range(0, 4) < 3), $urandom_range(0, NREGS - 1),
                            $urandom_range(0, 255));
                end
            end
        end
        cycle(g);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
